serial_char_tx: RTL and testbench
=================================

// Module: serial_char_tx
// PURPOSE
//   Serial transmitter driven by the Nios PIO outputs (parallel_input, load, transmit_enable).
//   Frames each byte as start bit, DATA_BITS data bits (LSB first), then STOP_BITS stop bits.
//   Has a one-entry holding register in front of the shift register, so back-to-back bytes go out with no idle gap.
//   Reports completion on char_sent, which feeds the Nios char_sent PIO input.
// PARAMETERS
//   CLKS_PER_BIT  16  clk_clk cycles per serial bit (>=2)
//   DATA_BITS     8   data bits per frame (1..8)
//   STOP_BITS     1   stop bits per frame (1 or 2)
// PORTS
//   clk_clk          in   1  single system clock
//   reset_reset_n    in   1  asynchronous, active-low reset
//   parallel_in      in   8  byte to send; bits [DATA_BITS-1:0] used
//   load             in   1  level; sampled each rising edge; high writes parallel_in into holding reg
//   transmit_enable  in   1  high permits a new frame to start
//   serial_out       out  1  line output, idles high
//   char_sent        out  1  one-cycle pulse at end of each frame's last stop bit
//   busy             out  1  high while a frame is in progress or holding reg is full
//   hold_full        out  1  holding register occupied
// BEHAVIOUR
//   Reset (async assert, sync release) drives: serial_out=1, char_sent=0, busy=0, hold_full=0.
//     It also sets state=IDLE and clears the bit counter and baud counter.
//     Reset mid-frame aborts the frame; line returns high immediately.
//   Holding reg: on load=1, hold<=parallel_in and hold_full<=1.
//     A load while already full overwrites; the last write wins.
//   FSM states: IDLE, START, DATA, STOP. baud_cnt counts 0..CLKS_PER_BIT-1 within each bit.
//   IDLE: if hold_full && transmit_enable, then shift<=hold, hold_full<=0, go to START.
//     serial_out goes 0 on the next cycle, so latency from a load seen in IDLE to the start edge is 2 cycles.
//   START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   DATA: serial_out=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx.
//     After bit DATA_BITS-1, go to STOP.
//   STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, char_sent=1 for that one cycle. Then:
//     if hold_full && transmit_enable: reload shift from hold and go directly to START (no idle bit);
//     otherwise go to IDLE.
//   Frame length is exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
//   Simultaneous load and hold->shift transfer in the same cycle:
//     the shift reg takes the OLD hold value; the new byte stays in hold with hold_full=1.
//   transmit_enable dropped mid-frame: the current frame completes normally; no new frame starts until it returns high.
//   load during a frame never disturbs the shift reg or the frame in flight.
//   busy = (state!=IDLE) | hold_full, registered with the state.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1)
//   Reset held low -> serial_out=1, char_sent=0, busy=0, hold_full=0.
//     Releasing reset with no load -> line stays high.
//   transmit_enable=1, load 0xA5 for 1 cycle -> serial_out: 0 for 4 cycles;
//     then 1,0,1,0,0,1,0,1 for 4 cycles each; then 1 for 4 cycles.
//     char_sent pulses once, at cycle 40 of the frame.
//   Load 0x3C, then load 0xC3 during the 0x3C data bits -> two frames back-to-back:
//     second start bit directly follows first stop bit; two char_sent pulses 40 cycles apart.
//   transmit_enable=0, load 0x55 -> hold_full=1, line stays high.
//     Raise enable -> frame starts 1 cycle later. Drop enable mid-frame -> frame still finishes.
//   Load 0x11 then 0x22 before enable -> only 0x22 is transmitted; exactly one char_sent.
//   Assert reset during DATA bit 3 -> serial_out=1 immediately, busy=0, no char_sent.
//     Then a new load transmits cleanly.

Source files
------------

// File: rtl/serial_char_tx.sv
// serial_char_tx
//   Serial transmitter fed from Nios PIO outputs. Each byte is framed as
//   one start bit (0), DATA_BITS data bits LSB first, then STOP_BITS stop
//   bits (1). A one-entry holding register sits in front of the shift
//   register, so a byte queued during a frame follows with no idle gap.
//
// Ports
//   clk_clk          in   system clock
//   reset_reset_n    in   asynchronous active-low reset
//   parallel_in      in   byte to send, bits [DATA_BITS-1:0] used
//   load             in   level, writes parallel_in into the holding register
//   transmit_enable  in   permits a new frame to start
//   serial_out       out  line output, idles high
//   char_sent        out  one-cycle pulse on the last cycle of the last stop bit
//   busy             out  frame in progress or holding register occupied
//   hold_full        out  holding register occupied
module serial_char_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] parallel_in,
    input  logic       load,
    input  logic       transmit_enable,
    output logic       serial_out,
    output logic       char_sent,
    output logic       busy,
    output logic       hold_full
);

    localparam int unsigned STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CW       = $clog2(STOP_LEN);
    localparam int unsigned BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] SENT_AT   = CW'(STOP_LEN - 2);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_idx;
    logic [7:0]    hold;
    logic [7:0]    shift;

    logic bit_end;
    logic stop_end;
    logic frame_slot;
    logic take;
    logic hold_full_nxt;
    logic idle_nxt;

    // A new frame may begin from IDLE or straight out of the final stop
    // cycle; both points share the same hold->shift transfer condition.
    always_comb begin
        bit_end       = (baud_cnt == BIT_LAST);
        stop_end      = (state == STOP) && (baud_cnt == STOP_LAST);
        frame_slot    = (state == IDLE) || stop_end;
        take          = frame_slot && hold_full && transmit_enable;
        // A load in the transfer cycle refills hold, so it stays full.
        hold_full_nxt = load || (hold_full && !take);
        idle_nxt      = frame_slot && !take;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            hold       <= '0;
            shift      <= '0;
            hold_full  <= 1'b0;
            serial_out <= 1'b1;
            char_sent  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            char_sent <= 1'b0;
            hold_full <= hold_full_nxt;
            busy      <= hold_full_nxt || !idle_nxt;
            if (load) begin
                hold <= parallel_in;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= START;
                        shift      <= hold;
                        baud_cnt   <= '0;
                        serial_out <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == IDX_LAST) begin
                            state      <= STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + BW'(1);
                            // Present the next bit together with the shift.
                            serial_out <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (stop_end) begin
                        baud_cnt <= '0;
                        if (take) begin
                            state      <= START;
                            shift      <= hold;
                            serial_out <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                        // Registered pulse lands on the final stop cycle.
                        if (baud_cnt == SENT_AT) begin
                            char_sent <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_char_tx.sv
// tb_serial_char_tx
//   Directed bench for serial_char_tx with CLKS_PER_BIT=4, DATA_BITS=8,
//   STOP_BITS=1. Inputs change and outputs are sampled on the falling edge.
module tb_serial_char_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] parallel_in;
    logic       load;
    logic       transmit_enable;
    logic       serial_out;
    logic       char_sent;
    logic       busy;
    logic       hold_full;

    int total = 0;
    int bad   = 0;

    serial_char_tx #(
        .CLKS_PER_BIT(4),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .parallel_in    (parallel_in),
        .load           (load),
        .transmit_enable(transmit_enable),
        .serial_out     (serial_out),
        .char_sent      (char_sent),
        .busy           (busy),
        .hold_full      (hold_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on the falling edge of the first start-bit cycle; walks all 40
    // frame cycles. Optionally loads a byte or drops enable at a given cycle.
    task automatic frame_check(input logic [7:0] b, input int ld_at,
                               input logic [7:0] ld_val, input int drop_at);
        for (int i = 0; i < 40; i++) begin
            logic e;
            if (i < 4)       e = 1'b0;
            else if (i < 36) e = b[(i - 4) / 4];
            else             e = 1'b1;
            check($sformatf("%02h_line_c%0d", b, i + 1), serial_out, e);
            check($sformatf("%02h_sent_c%0d", b, i + 1), char_sent, (i == 39));
            check($sformatf("%02h_busy_c%0d", b, i + 1), busy, 1'b1);
            if (i == ld_at) begin
                load        = 1'b1;
                parallel_in = ld_val;
            end else begin
                load = 1'b0;
            end
            if (i == drop_at) transmit_enable = 1'b0;
            @(negedge clk);
        end
    endtask

    // Watches an idle window; line must stay high with no char_sent.
    task automatic quiet_check(input string tag, input int cycles);
        int lows  = 0;
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (serial_out !== 1'b1) lows++;
            if (char_sent !== 1'b0) pulses++;
            @(negedge clk);
        end
        check({tag, "_lows"}, lows, 0);
        check({tag, "_pulses"}, pulses, 0);
    endtask

    task automatic load_byte(input logic [7:0] v);
        load        = 1'b1;
        parallel_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        load            = 1'b0;
        parallel_in     = '0;
        transmit_enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_line", serial_out, 1'b1);
        check("rst_sent", char_sent, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hold", hold_full, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        quiet_check("post_rst", 10);
        check("post_rst_busy", busy, 1'b0);

        // Single frame 0xA5, two-cycle start latency
        transmit_enable = 1'b1;
        load_byte(8'hA5);
        check("a5_hold_full", hold_full, 1'b1);
        check("a5_busy_pre", busy, 1'b1);
        check("a5_line_pre", serial_out, 1'b1);
        @(negedge clk);
        frame_check(8'hA5, -1, 8'h00, -1);
        check("a5_after_busy", busy, 1'b0);
        check("a5_after_hold", hold_full, 1'b0);
        quiet_check("a5_after", 8);

        // Back-to-back 0x3C then 0xC3 loaded during the 0x3C data bits
        load_byte(8'h3C);
        @(negedge clk);
        frame_check(8'h3C, 10, 8'hC3, -1);
        frame_check(8'hC3, -1, 8'h00, -1);
        check("b2b_after_busy", busy, 1'b0);
        quiet_check("b2b_after", 8);

        // Held byte with enable low, then enable dropped mid-frame
        transmit_enable = 1'b0;
        load_byte(8'h55);
        repeat (4) @(negedge clk);
        check("en0_hold_full", hold_full, 1'b1);
        check("en0_busy", busy, 1'b1);
        quiet_check("en0_wait", 6);
        transmit_enable = 1'b1;
        @(negedge clk);
        frame_check(8'h55, -1, 8'h00, 20);
        check("drop_after_busy", busy, 1'b0);
        check("drop_after_line", serial_out, 1'b1);

        // Overwrite before enable: only 0x22 goes out
        load_byte(8'h11);
        load_byte(8'h22);
        check("ovw_hold_full", hold_full, 1'b1);
        quiet_check("ovw_wait", 3);
        transmit_enable = 1'b1;
        @(negedge clk);
        frame_check(8'h22, -1, 8'h00, -1);
        check("ovw_after_hold", hold_full, 1'b0);
        quiet_check("ovw_after", 50);

        // Reset during data bit 3 of 0x96 (bit 3 = 0)
        load_byte(8'h96);
        @(negedge clk);
        check("rmid_start", serial_out, 1'b0);
        repeat (17) @(negedge clk);
        check("rmid_bit3", serial_out, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rmid_line", serial_out, 1'b1);
        check("rmid_busy", busy, 1'b0);
        check("rmid_sent", char_sent, 1'b0);
        check("rmid_hold", hold_full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_check("rmid_after", 40);
        load_byte(8'hE7);
        @(negedge clk);
        frame_check(8'hE7, -1, 8'h00, -1);
        check("e7_after_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
